// File: rtl/cache_pkg.sv
// cache_pkg: shared types, default geometry and width helpers for the line-fill controller
package cache_pkg;
  typedef enum logic {FILL_IDLE, FILL_BUSY} fill_state_t;
  localparam int BYTE_W = 1;
  localparam int OFF_W = 3;
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
endpackage

// File: rtl/fill_word_counter.sv
// fill_word_counter: modulo-N up counter with synchronous load and enable
module fill_word_counter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt == W'(N - 1) ? '0 : cnt + W'(1);
endmodule

// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: cache line fill with bounded outstanding reads and write-through hits
// Optional critical-word-first ordering: define CRITICAL_WORD_FIRST_EN
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORD_BYTES = 1 << BYTE_W,
  parameter int WORDS_PER_LINE = 1 << OFF_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              wrt,
  input  logic              pause,
  input  logic              mem_data_valid,
  output logic              fsm_busy,
  output logic              read_request,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wrt_mem,
  output logic              wrt_data_array,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              wrt_tag_array,
  output logic              fill_err
);
  localparam int bw = $clog2(WORD_BYTES);
  localparam int ow = $clog2(WORDS_PER_LINE);
  localparam int cw = cnt_w(MAX_OUTSTANDING);
  localparam int lw = ADDR_W - ow - bw;
  localparam logic [ow:0] words = (ow + 1)'(WORDS_PER_LINE);
  localparam logic [cw-1:0] max_out = cw'(MAX_OUTSTANDING);
  fill_state_t state;
  logic [lw-1:0] line;
  logic [ow:0] issued, returned;
  logic [cw-1:0] outstanding;
  logic [ow-1:0] start, issue_idx, ret_idx;
  logic idle, start_fill, issue_ok, ret_ok, last;
  assign idle = state == FILL_IDLE;
  assign start_fill = idle && miss;
`ifdef CRITICAL_WORD_FIRST_EN
  assign start = miss_addr[ow+bw-1:bw];
`else
  assign start = '0;
`endif
  assign issue_ok = !idle && !pause && outstanding < max_out && issued < words;
  // a return with nothing in flight is a protocol error, never a data write
  assign ret_ok = !idle && mem_data_valid && outstanding != '0;
  assign last = ret_ok && returned == words - (ow + 1)'(1);
  assign fsm_busy = idle ? miss : 1'b1;
  assign read_request = issue_ok;
  assign mem_addr = idle ? miss_addr : {line, issue_idx, {bw{1'b0}}};
  assign wrt_mem = idle && wrt && !miss;
  assign wrt_data_array = idle ? wrt && !miss : ret_ok;
  assign cache_addr = idle ? miss_addr : {line, ret_idx, {bw{1'b0}}};
  assign wrt_tag_array = last;
  fill_word_counter #(.N(WORDS_PER_LINE)) u_issue (
    .clk(clk), .rst(rst), .load(start_fill), .en(issue_ok), .load_val(start), .cnt(issue_idx)
  );
  fill_word_counter #(.N(WORDS_PER_LINE)) u_ret (
    .clk(clk), .rst(rst), .load(start_fill), .en(ret_ok), .load_val(start), .cnt(ret_idx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FILL_IDLE;
      line <= '0;
      issued <= '0;
      returned <= '0;
      outstanding <= '0;
      fill_err <= 1'b0;
    end else if (start_fill) begin
      state <= FILL_BUSY;
      line <= miss_addr[ADDR_W-1:ow+bw];
      issued <= '0;
      returned <= '0;
      outstanding <= '0;
    end else if (!idle) begin
      issued <= issued + (ow + 1)'(issue_ok);
      returned <= returned + (ow + 1)'(ret_ok);
      outstanding <= outstanding + cw'(issue_ok) - cw'(ret_ok);
      fill_err <= fill_err || (mem_data_valid && outstanding == '0);
      if (last) state <= FILL_IDLE;
    end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// tb_cache_line_fill_ctrl: directed checks of hit writes, fills, pause, outstanding limit and reset abort
module tb_cache_line_fill_ctrl;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam int S = 3;
`else
  localparam int S = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, miss = 1'b0, wrt = 1'b0, pause = 1'b0, valid = 1'b0;
  logic [15:0] addr = 16'h5A5A;
  logic fsm_busy, read_request, wrt_mem, wrt_data_array, wrt_tag_array, fill_err;
  logic [15:0] mem_addr, cache_addr;
  logic fsm_busy2, read_request2, wrt_mem2, wrt_data_array2, wrt_tag_array2, fill_err2;
  logic [15:0] mem_addr2, cache_addr2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cache_line_fill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(addr), .wrt(wrt), .pause(pause),
    .mem_data_valid(valid), .fsm_busy(fsm_busy), .read_request(read_request), .mem_addr(mem_addr),
    .wrt_mem(wrt_mem), .wrt_data_array(wrt_data_array), .cache_addr(cache_addr),
    .wrt_tag_array(wrt_tag_array), .fill_err(fill_err)
  );
  cache_line_fill_ctrl #(.MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(addr), .wrt(wrt), .pause(pause),
    .mem_data_valid(valid), .fsm_busy(fsm_busy2), .read_request(read_request2), .mem_addr(mem_addr2),
    .wrt_mem(wrt_mem2), .wrt_data_array(wrt_data_array2), .cache_addr(cache_addr2),
    .wrt_tag_array(wrt_tag_array2), .fill_err(fill_err2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_addr(input int n);
    return 32'h4000 + 32'(((S + n) % 8) * 2);
  endfunction
  task automatic cyc(input logic m, input logic w, input logic p, input logic v, input logic [15:0] a);
    @(posedge clk);
    #1;
    miss = m; wrt = w; pause = p; valid = v; addr = a;
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0; miss = 1'b0; wrt = 1'b0; pause = 1'b0; valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask
  task automatic start_miss();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h4006);
    chk("miss_busy", fsm_busy, 1);
    chk("miss_no_wrt", {wrt_mem, wrt_data_array, read_request}, 0);
  endtask
  task automatic fill(input logic [15:0] pmask, input logic [15:0] rmask, input int tagc, input int ncyc);
    int nis = 0;
    int nret = 0;
    logic [1:0] pipe = 2'b00;
    for (int k = 1; k <= ncyc; k++) begin
      cyc(1'b0, k <= tagc, pmask[k], pipe[1], 16'h4006);
      chk($sformatf("rr_c%0d", k), read_request, rmask[k]);
      if (read_request) begin
        chk($sformatf("issue_addr_%0d", nis), mem_addr, exp_addr(nis));
        nis++;
      end
      chk($sformatf("wda_c%0d", k), wrt_data_array, pipe[1]);
      if (pipe[1]) begin
        chk($sformatf("ret_addr_%0d", nret), cache_addr, exp_addr(nret));
        nret++;
      end
      chk($sformatf("tag_c%0d", k), wrt_tag_array, k == tagc);
      chk($sformatf("busy_c%0d", k), fsm_busy, k <= tagc);
      chk($sformatf("wrt_mem_c%0d", k), wrt_mem, 0);
      pipe = {pipe[0], read_request};
    end
    chk("n_issued", nis, 8);
    chk("fill_err_clean", fill_err, 0);
  endtask
  initial begin
    int c1, c2;
    logic busy_all;
    logic [1:0] pipe;
    @(posedge clk);
    #2;
    chk("rst_strobes", {fsm_busy, read_request, wrt_mem, wrt_data_array, wrt_tag_array, fill_err}, 0);
    chk("rst_mem_addr", mem_addr, 16'h5A5A);
    chk("rst_cache_addr", cache_addr, 16'h5A5A);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    chk("hit_wrt", {wrt_mem, wrt_data_array, fsm_busy}, 3'b110);
    chk("hit_mem_addr", mem_addr, 16'h1234);
    chk("hit_cache_addr", cache_addr, 16'h1234);
    start_miss();
    fill(16'h0000, 16'h01FE, 10, 11);
    start_miss();
    fill(16'h0038, 16'h0FC6, 13, 14);
    do_reset();
    start_miss();
    c1 = 0; c2 = 0; busy_all = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h4006);
      c1 += int'(read_request);
      c2 += int'(read_request2);
      busy_all &= fsm_busy & fsm_busy2;
    end
    chk("stall_rr_max4", c1, 4);
    chk("stall_rr_max2", c2, 2);
    chk("stall_busy", busy_all, 1);
    do_reset();
    start_miss();
    pipe = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, pipe[1], 16'h4006);
      pipe = {pipe[0], read_request};
    end
    @(posedge clk);
    #1 valid = pipe[1]; rst = 1'b0;
    #1;
    chk("abort_strobes", {fsm_busy, read_request, wrt_mem, wrt_data_array, wrt_tag_array, fill_err}, 0);
    chk("abort_mem_addr", mem_addr, 16'h4006);
    chk("abort_cache_addr", cache_addr, 16'h4006);
    @(posedge clk);
    #2;
    chk("abort_no_tag", wrt_tag_array, 0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h4006);
    chk("idle_valid_no_wda", wrt_data_array, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h4006);
    chk("idle_valid_no_err", fill_err, 0);
    start_miss();
    fill(16'h0000, 16'h01FE, 10, 11);
    start_miss();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h4006);
    chk("spurious_no_wda", {wrt_data_array, wrt_tag_array}, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h4006);
    chk("spurious_err", fill_err, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
